// File: rtl/gol_pkg.sv
// gol_pkg
// Shared constants for the Game-of-Life grid engine: neighbour bit positions
// inside the 8-bit neighbour mask, default B3/S23 rule masks, FSM state
// encodings and a small width helper.
package gol_pkg;

  // Bit positions in the neighbour mask {UL, UP, UR, L, R, DL, DN, DR}.
  localparam int NB_UL = 7;
  localparam int NB_UP = 6;
  localparam int NB_UR = 5;
  localparam int NB_L  = 4;
  localparam int NB_R  = 3;
  localparam int NB_DL = 2;
  localparam int NB_DN = 1;
  localparam int NB_DR = 0;

  // Bit n set: a cell with n live neighbours is born / survives.
  localparam logic [8:0] DEF_BIRTH_MASK   = 9'b000001000;
  localparam logic [8:0] DEF_SURVIVE_MASK = 9'b000001100;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SWEEP = 2'd1;
  localparam state_t ST_SWAP  = 2'd2;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/gol_grid_engine_neigh_fetch.sv
// gol_neigh_fetch
// Combinational gather of the 8 neighbours of one cell in a column-major
// flattened grid (index = col*ROWS + row), plus their population count.
// Ports:
//   grid  - flattened ROWS*COLS cell vector
//   row   - cell row
//   col   - cell column
//   neigh - {UL, UP, UR, L, R, DL, DN, DR}
//   count - number of set bits in neigh (0..8)
module gol_neigh_fetch
  import gol_pkg::*;
#(
  parameter int ROWS = 15,
  parameter int COLS = 20,
  parameter int WRAP = 0,
  parameter int RW   = 4,
  parameter int CW   = 5
) (
  input  logic [ROWS*COLS-1:0] grid,
  input  logic [RW-1:0]        row,
  input  logic [CW-1:0]        col,
  output logic [7:0]           neigh,
  output logic [3:0]           count
);

  localparam int N  = ROWS * COLS;
  localparam int IW = clog2_min1(N);

  // Coordinates may be one step off-grid; they either wrap or read as 0.
  // The final bounds check also covers row/col values outside the grid.
  function automatic logic cell_at(input logic [N-1:0] g, input int r_in, input int c_in);
    int r;
    int c;
    r = r_in;
    c = c_in;
    if (WRAP != 0) begin
      if (r < 0) r = ROWS - 1;
      else if (r >= ROWS) r = 0;
      if (c < 0) c = COLS - 1;
      else if (c >= COLS) c = 0;
    end
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
    return g[IW'(c * ROWS + r)];
  endfunction

  always_comb begin
    neigh        = '0;
    neigh[NB_UL] = cell_at(grid, int'(row) - 1, int'(col) - 1);
    neigh[NB_UP] = cell_at(grid, int'(row) - 1, int'(col));
    neigh[NB_UR] = cell_at(grid, int'(row) - 1, int'(col) + 1);
    neigh[NB_L]  = cell_at(grid, int'(row),     int'(col) - 1);
    neigh[NB_R]  = cell_at(grid, int'(row),     int'(col) + 1);
    neigh[NB_DL] = cell_at(grid, int'(row) + 1, int'(col) - 1);
    neigh[NB_DN] = cell_at(grid, int'(row) + 1, int'(col));
    neigh[NB_DR] = cell_at(grid, int'(row) + 1, int'(col) + 1);
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) count = count + 4'(neigh[i]);
  end

endmodule

// File: rtl/gol_grid_engine.sv
// gol_grid_engine
// Double-buffered Game-of-Life cell store with an edit/display port and a
// one-cell-per-clock generation sweep into the shadow bank.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | edit port live (clear > write); step_i starts a sweep
//   ST_SWEEP | shadow[s] <= rule(active[s], neighbours); s = 0..N-1
//   ST_SWAP  | toggle active bank, bump gen_o, raise done_o
//
// Ports:
//   clk_50MHz_i, rst_i      - clock, synchronous active-high reset
//   addr_i, data_i, w_e_i   - cell address (col*ROWS+row), write data/enable
//   clear_i, step_i         - clear active bank, request one generation
//   data_o, neigh_o, count_o- active-bank cell / neighbour mask / count
//   busy_o, done_o, gen_o   - sweep in progress, swap pulse, generation count
module gol_grid_engine
  import gol_pkg::*;
#(
  parameter int         ROWS         = 15,
  parameter int         COLS         = 20,
  parameter int         ADDR_W       = 9,
  parameter int         WRAP         = 0,
  parameter logic [8:0] BIRTH_MASK   = DEF_BIRTH_MASK,
  parameter logic [8:0] SURVIVE_MASK = DEF_SURVIVE_MASK,
  parameter int         GEN_W        = 16
) (
  input  logic              clk_50MHz_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              data_i,
  input  logic              w_e_i,
  input  logic              clear_i,
  input  logic              step_i,
  output logic              data_o,
  output logic [7:0]        neigh_o,
  output logic [3:0]        count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [GEN_W-1:0]  gen_o
);

  localparam int N  = ROWS * COLS;
  localparam int IW = clog2_min1(N);
  localparam int RW = clog2_min1(ROWS);
  localparam int CW = clog2_min1(COLS);

  logic [N-1:0]  bank_a;
  logic [N-1:0]  bank_b;
  logic [N-1:0]  cur;
  logic          sel;
  state_t        state;

  logic [IW-1:0] s;
  logic [RW-1:0] srow;
  logic [CW-1:0] scol;

  logic          valid;
  logic [IW-1:0] eidx;
  logic [RW-1:0] erow;
  logic [CW-1:0] ecol;
  logic [7:0]    eneigh;
  logic [7:0]    sneigh;
  logic [3:0]    ecount;
  logic [3:0]    scount;
  logic          nxt;

  // sel = 0: bank_a is displayed and bank_b is the shadow; sel = 1: swapped.
  assign cur   = sel ? bank_b : bank_a;

  assign valid = int'(addr_i) < N;
  assign eidx  = IW'(addr_i);
  assign erow  = RW'(int'(addr_i) % ROWS);
  assign ecol  = CW'(int'(addr_i) / ROWS);

  gol_neigh_fetch #(
    .ROWS(ROWS), .COLS(COLS), .WRAP(WRAP), .RW(RW), .CW(CW)
  ) u_edit_fetch (
    .grid (cur),
    .row  (erow),
    .col  (ecol),
    .neigh(eneigh),
    .count(ecount)
  );

  // Sweep row/col are tracked as counters alongside s to avoid a divider.
  gol_neigh_fetch #(
    .ROWS(ROWS), .COLS(COLS), .WRAP(WRAP), .RW(RW), .CW(CW)
  ) u_sweep_fetch (
    .grid (cur),
    .row  (srow),
    .col  (scol),
    .neigh(sneigh),
    .count(scount)
  );

  assign data_o  = valid ? cur[eidx] : 1'b0;
  assign neigh_o = valid ? eneigh : 8'd0;
  assign count_o = valid ? ecount : 4'd0;
  assign busy_o  = (state != ST_IDLE);

  assign nxt = cur[s] ? SURVIVE_MASK[scount] : BIRTH_MASK[scount];

  always_ff @(posedge clk_50MHz_i) begin
    if (rst_i) begin
      bank_a <= '0;
      bank_b <= '0;
      sel    <= 1'b0;
      state  <= ST_IDLE;
      s      <= '0;
      srow   <= '0;
      scol   <= '0;
      done_o <= 1'b0;
      gen_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_i) begin
            if (sel) bank_b <= '0;
            else     bank_a <= '0;
          end else if (w_e_i && valid) begin
            if (sel) bank_b[eidx] <= data_i;
            else     bank_a[eidx] <= data_i;
          end
          if (step_i) begin
            state <= ST_SWEEP;
            s     <= '0;
            srow  <= '0;
            scol  <= '0;
          end
        end
        ST_SWEEP: begin
          if (sel) bank_a[s] <= nxt;
          else     bank_b[s] <= nxt;
          if (s == IW'(N - 1)) begin
            state <= ST_SWAP;
          end else begin
            s <= s + IW'(1);
            if (srow == RW'(ROWS - 1)) begin
              srow <= '0;
              scol <= scol + CW'(1);
            end else begin
              srow <= srow + RW'(1);
            end
          end
        end
        ST_SWAP: begin
          sel    <= ~sel;
          gen_o  <= gen_o + GEN_W'(1);
          done_o <= 1'b1;
          state  <= ST_IDLE;
          s      <= '0;
          srow   <= '0;
          scol   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
